// File: rtl/div128x64_m.sv
// div128x64_m: unsigned 128/64 restoring divider, one quotient bit per clock by default.
// Defining DIV128X64_RADIX4_EN retires two quotient bits per clock through two cascaded trial subtractions.
//
// state | meaning
// IDLE  | ready=1, results held, waiting for start
// CALC  | iterating the shift/trial-subtract loop
// ZERO  | divisor was zero, publish the saturated result on the next edge
module div128x64_m (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic [127:0] a,
    input  logic [63:0]  b,
    output logic [127:0] q,
    output logic [63:0]  r,
    output logic         dz
);

    typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;

    typedef struct packed {
        logic [63:0]  rem;
        logic [127:0] quot;
    } step_t;

`ifdef DIV128X64_RADIX4_EN
    localparam logic [6:0] LAST_CNT = 7'd63;
`else
    localparam logic [6:0] LAST_CNT = 7'd127;
`endif

    state_t        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [63:0]   rem_q, rem_d;
    logic [127:0]  quot_q, quot_d;
    logic [63:0]   dvs_q, dvs_d;
    logic [127:0]  q_res_q, q_res_d;
    logic [63:0]   r_res_q, r_res_d;
    logic          dz_q, dz_d;
    logic          ready_q, ready_d;
    step_t         cur_w, nxt_w;

    // When the trial difference is non-negative it is below 2^64, so the
    // low 64 bits of the subtraction are the exact new remainder.
    function automatic step_t div_step(input step_t s, input logic [63:0] dvs);
        logic [64:0] shifted;
        logic        ge;
        step_t       o;
        shifted = {s.rem, s.quot[127]};
        ge      = (shifted >= {1'b0, dvs});
        o.quot  = {s.quot[126:0], ge};
        o.rem   = ge ? (shifted[63:0] - dvs) : shifted[63:0];
        return o;
    endfunction

    always_comb begin
        cur_w = '{rem: rem_q, quot: quot_q};
`ifdef DIV128X64_RADIX4_EN
        nxt_w = div_step(div_step(cur_w, dvs_q), dvs_q);
`else
        nxt_w = div_step(cur_w, dvs_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        q_res_d = q_res_q;
        r_res_d = r_res_q;
        dz_d    = dz_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d   = b;
                    quot_d  = a;
                    rem_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = (b == 64'd0) ? ZERO : CALC;
                end
            end
            CALC: begin
                rem_d  = nxt_w.rem;
                quot_d = nxt_w.quot;
                cnt_d  = cnt_q + 7'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    q_res_d = nxt_w.quot;
                    r_res_d = nxt_w.rem;
                    dz_d    = 1'b0;
                end
            end
            ZERO: begin
                state_d = IDLE;
                ready_d = 1'b1;
                q_res_d = '1;
                r_res_d = quot_q[63:0];
                dz_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            q_res_q <= '0;
            r_res_q <= '0;
            dz_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            q_res_q <= q_res_d;
            r_res_q <= r_res_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign q     = q_res_q;
    assign r     = r_res_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_div128x64_m.sv
// tb_div128x64_m: randomized self-checking bench for div128x64_m.
// Expected results come from native 128-bit / and % in the bench.
module tb_div128x64_m;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic [127:0] a;
    logic [63:0]  b;
    logic [127:0] q;
    logic [63:0]  r;
    logic         dz;

    int checks   = 0;
    int failures = 0;

`ifdef DIV128X64_RADIX4_EN
    localparam int LAT = 64;
`else
    localparam int LAT = 128;
`endif

    always #5 clk = ~clk;

    div128x64_m dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issues one start pulse, scrambles a/b after the accepting edge and
    // returns the number of edges until ready rises (-1 on timeout).
    task automatic run_op(input logic [127:0] av, input logic [63:0] bv,
                          output int lat, output bit stable, output bit busy0);
        logic [127:0] q0;
        logic [63:0]  r0;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = rnd128(); b = rnd64();
        busy0 = (ready === 1'b0);
        q0 = q; r0 = r; stable = 1'b1; lat = -1;
        if (ready === 1'b1) lat = 0;
        for (int n = 1; n <= 300 && lat < 0; n++) begin
            @(posedge clk); #1;
            a = rnd128(); b = rnd64();
            if (ready === 1'b1) lat = n;
            else if (q !== q0 || r !== r0) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = rnd128(); b = 64'd5;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (q !== 128'd0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
        checks++; if (r !== 64'd0) begin failures++; $display("FAIL reset_r got=%h exp=0", r); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_priority ready got=%b exp=1", ready); end
    endtask

    task automatic test_basic();
        int lat; bit stable, busy0;
        logic [127:0] qh; logic [63:0] rh;
        run_op(128'd100, 64'd7, lat, stable, busy0);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (!busy0) begin failures++; $display("FAIL basic_busy ready not low after accept"); end
        checks++; if (!stable) begin failures++; $display("FAIL basic_stable q/r changed during calc"); end
        checks++; if (q !== 128'd14) begin failures++; $display("FAIL basic_q got=%0d exp=14", q); end
        checks++; if (r !== 64'd2) begin failures++; $display("FAIL basic_r got=%0d exp=2", r); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL basic_dz got=%b exp=0", dz); end
        qh = q; rh = r;
        repeat (10) begin
            a = rnd128(); b = rnd64();
            @(posedge clk); #1;
        end
        checks++; if (q !== 128'd14 || r !== 64'd2 || ready !== 1'b1) begin
            failures++; $display("FAIL basic_hold q=%0d r=%0d ready=%b exp q=14 r=2 ready=1", q, r, ready);
        end
    endtask

    task automatic test_max();
        int lat; bit stable, busy0;
        run_op({128{1'b1}}, {64{1'b1}}, lat, stable, busy0);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL max_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (q !== 128'h0000000000000001_0000000000000001) begin failures++; $display("FAIL max_q got=%h exp=00000000000000010000000000000001", q); end
        checks++; if (r !== 64'd0) begin failures++; $display("FAIL max_r got=%h exp=0", r); end
    endtask

    task automatic test_zero();
        int lat; bit stable, busy0;
        run_op(128'h1234, 64'd0, lat, stable, busy0);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        checks++; if (q !== {128{1'b1}}) begin failures++; $display("FAIL zero_q got=%h exp=all ones", q); end
        checks++; if (r !== 64'h1234) begin failures++; $display("FAIL zero_r got=%h exp=1234", r); end
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL zero_dz got=%b exp=1", dz); end
        run_op(128'h1234, 64'd3, lat, stable, busy0);
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL zero_next_dz got=%b exp=0", dz); end
        checks++; if (q !== 128'h1234 / 128'd3 || r !== 64'h1234 % 64'd3) begin
            failures++; $display("FAIL zero_next_qr q=%h r=%h exp q=%h r=%h", q, r, 128'h1234 / 128'd3, 64'h1234 % 64'd3);
        end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL zero_next_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_reset_mid();
        int lat; bit stable, busy0;
        a = rnd128(); b = rnd64() | 64'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || q !== 128'd0 || r !== 64'd0 || dz !== 1'b0) begin
            failures++; $display("FAIL midreset_state ready=%b q=%h r=%h dz=%b exp 1/0/0/0", ready, q, r, dz);
        end
        repeat (LAT + 5) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1 || q !== 128'd0 || r !== 64'd0) begin
            failures++; $display("FAIL midreset_discard ready=%b q=%h r=%h exp 1/0/0", ready, q, r);
        end
        run_op(128'd10, 64'd3, lat, stable, busy0);
        checks++; if (q !== 128'd3 || r !== 64'd1) begin failures++; $display("FAIL midreset_next q=%0d r=%0d exp q=3 r=1", q, r); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL midreset_next_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_boundaries();
        int lat; bit stable, busy0;
        logic [127:0] av;
        run_op(128'd5, 64'd9, lat, stable, busy0);
        checks++; if (q !== 128'd0 || r !== 64'd5) begin failures++; $display("FAIL a_lt_b q=%0d r=%0d exp q=0 r=5", q, r); end
        av = rnd128();
        run_op(av, 64'd1, lat, stable, busy0);
        checks++; if (q !== av || r !== 64'd0) begin failures++; $display("FAIL b_is_one q=%h r=%h exp q=%h r=0", q, r, av); end
        run_op(128'd0, rnd64() | 64'd1, lat, stable, busy0);
        checks++; if (q !== 128'd0 || r !== 64'd0) begin failures++; $display("FAIL a_is_zero q=%h r=%h exp 0/0", q, r); end
    endtask

    typedef struct {
        logic [127:0] av;
        logic [63:0]  bv;
    } op_t;

    task automatic test_back_to_back();
        op_t          exp_q[$];
        op_t          e;
        int           ops = 0;
        int           run = 0;
        logic [127:0] ac, qe;
        logic [63:0]  bc, re;
        bit           rp;
        a = rnd128(); b = rnd64() | 64'd1; start = 1'b1;
        for (int cyc = 0; cyc < 4 * LAT + 40 && ops < 3; cyc++) begin
            ac = a; bc = b; rp = ready;
            if (rp) run++;
            @(posedge clk); #1;
            if (rp && start) exp_q.push_back('{av: ac, bv: bc});
            if (rp && ready !== 1'b1) begin
                checks++; if (run !== 1) begin failures++; $display("FAIL b2b_idle_cycles got=%0d exp=1", run); end
                run = 0;
            end
            if (!rp && ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_completion");
                end else begin
                    e = exp_q.pop_front();
                    qe = e.av / {64'd0, e.bv};
                    re = 64'(e.av % {64'd0, e.bv});
                    if (q !== qe || r !== re || dz !== 1'b0) begin
                        failures++; $display("FAIL b2b_result q=%h r=%h dz=%b exp q=%h r=%h dz=0", q, r, dz, qe, re);
                    end
                end
                ops++;
            end
            a = rnd128(); b = rnd64() | 64'd1;
        end
        start = 1'b0;
        checks++; if (ops !== 3) begin failures++; $display("FAIL b2b_ops_completed got=%0d exp=3", ops); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; bit stable, busy0;
        logic [63:0]  x, y, bv;
        logic [127:0] av, qe, rm;
        int           bad = 0;
        for (int i = 0; i < 30; i++) begin
            x = rnd64(); y = rnd64();
            av = {64'd0, x} * {64'd0, y};
            case (i % 3)
                0: bv = rnd64();
                1: bv = 64'($urandom_range(1, 1000));
                default: bv = {32'd0, $urandom()};
            endcase
            if (bv == 64'd0) bv = 64'd1;
            qe = av / {64'd0, bv};
            rm = av % {64'd0, bv};
            run_op(av, bv, lat, stable, busy0);
            checks++;
            if (q !== qe || r !== rm[63:0] || dz !== 1'b0 || lat !== LAT || !stable) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL random_op a=%h b=%h q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d", av, bv, q, r, lat, qe, rm[63:0], LAT);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_reset_mid();
        test_boundaries();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
